// File: rtl/vga_sync_gen.sv
// Raster timing generator: free-running h/v counters with registered, zero-skew sync/draw decodes.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 10
) (
   input  logic          pixelclock,
   input  logic          nreset,
   input  logic          pix_en,
   output logic          hsinc,
   output logic          vsinc,
   output logic          draw,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

   logic [CW-1:0] x_next;
   logic [CW-1:0] y_next;
   logic          draw_next;
   logic          hsinc_next;
   logic          vsinc_next;
   logic          line_start_next;
   logic          frame_start_next;

   // Decodes are taken from the next position so every output lands on the same edge as x/y.
   always_comb begin
      x_next = x + CW'(1);
      y_next = y;
      if (x == H_LAST) begin
         x_next = '0;
         if (y == V_LAST) y_next = '0;
         else             y_next = y + CW'(1);
      end
      draw_next        = (int'(x_next) < H_ACTIVE) && (int'(y_next) < V_ACTIVE);
      hsinc_next       = ((int'(x_next) >= HS_BEG) && (int'(x_next) < HS_END)) ? HS_POL : !HS_POL;
      vsinc_next       = ((int'(y_next) >= VS_BEG) && (int'(y_next) < VS_END)) ? VS_POL : !VS_POL;
      line_start_next  = (x_next == '0);
      frame_start_next = (x_next == '0) && (y_next == '0);
   end

   always_ff @(posedge pixelclock or negedge nreset) begin
      if (!nreset) begin
         x           <= H_LAST;
         y           <= V_LAST;
         hsinc       <= !HS_POL;
         vsinc       <= !VS_POL;
         draw        <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         x           <= x_next;
         y           <= y_next;
         hsinc       <= hsinc_next;
         vsinc       <= vsinc_next;
         draw        <= draw_next;
         line_start  <= line_start_next;
         frame_start <= frame_start_next;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge pixelclock or negedge nreset) begin
      if (!nreset)                        frame_cnt_q <= 8'd0;
      else if (pix_en && frame_start_next) frame_cnt_q <= frame_cnt_q + 8'd1;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 8'd0;
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator directly upstream of the on-screen time/digit renderer.
- Produces the raster timing the renderer consumes: hsinc, vsinc, draw, plus the current pixel column/row.
- Free-running h/v counters advance on a pixel-enable strobe. All outputs are registered and mutually aligned.
- Default timing is 640x480@60 (25 MHz pixel rate). Every timing value is parameterised.

Parameters:
H_ACTIVE, 640, visible columns
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible rows
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsinc active level (0 = active-low)
VS_POL, 0, vsinc active level (0 = active-low)
CW, 10, counter width (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
pixelclock  in   1   single clock
nreset      in   1   asynchronous, active-low reset
pix_en      in   1   advance strobe: 1 every cycle for a native pixel clock, 1 every 2nd cycle for a 50 MHz source
hsinc       out  1   horizontal sync, polarity per HS_POL
vsinc       out  1   vertical sync, polarity per VS_POL
draw        out  1   1 while (x,y) is inside the active area
x           out  CW  current column, 0..H_TOTAL-1
y           out  CW  current row, 0..V_TOTAL-1
line_start  out  1   1 while x==0
frame_start out  1   1 while x==0 && y==0
frame_cnt   out  8   frame counter (see Optional Feature)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset (nreset=0, asynchronous):
  - x = H_TOTAL-1, y = V_TOTAL-1.
  - hsinc = !HS_POL, vsinc = !VS_POL.
  - draw = 0, line_start = 0, frame_start = 0, frame_cnt = 0.
  - This position lies in both back porches, so all outputs are consistent with the decode rules.
- Advance on a rising edge with pix_en=1:
  - If x == H_TOTAL-1: x wraps to 0.
    - If y == V_TOTAL-1, y wraps to 0; otherwise y increments.
  - Otherwise x increments and y holds.
- pix_en=0: every output holds its value, pulses included (a pulse lasts for its whole pixel period).
- Decode invariants, true in every cycle with outputs registered (no combinational path from counters to ports):
  - draw = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hsinc = HS_POL while H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; else !HS_POL.
  - vsinc = VS_POL while V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; else !VS_POL. vsinc changes only on edges where x wraps to 0.
  - line_start = (x == 0); frame_start = (x == 0 && y == 0).
- Implementation rule: compute next x/y, decode the next values, and register the decodes. Outputs then change on the same edge as x/y, with zero skew between any two outputs.
- Latency after reset release: the first edge with pix_en=1 gives x=0, y=0, draw=1, line_start=1, frame_start=1.
- Reset asserted mid-frame returns to the reset state immediately. No partial line or frame state is retained.
- Default timing per line: exactly 96 pix_en cycles with hsinc low. Per frame: exactly 2 lines with vsinc low, and 307200 pixel periods with draw=1.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1 on every edge where frame_start becomes 1. It wraps 255 -> 0 and resets to 0. The downstream renderer uses it to blink the colon glyph.
- Undefined: frame_cnt is tied to 8'd0 and no counter register is synthesised. All other behaviour is identical.

Test Plan:
- Reset, release, pix_en=1 constant -> first edge gives x=0, y=0, draw=1, frame_start=1; x=639 draw=1; x=640 draw=0.
- Run one line -> hsinc low for exactly x=656..751 (96 cycles); line_start high once per 800 cycles.
- Run full frame -> vsinc low only for y=490..491; y wraps 524 -> 0 together with x wrapping 799 -> 0; frame period is 420000 cycles.
- pix_en toggling 1,0,1,0 -> frame period is 840000 clocks; outputs hold for 2 clocks each; no output toggles on a pix_en=0 edge.
- Assert nreset at x=300, y=200 (mid-frame, asynchronously) -> outputs go immediately to the reset state (x=799, y=524, draw=0, syncs inactive); after release, restart at (0,0).
- With VGA_FRAME_CNT_EN: after 256 frames frame_cnt reads 0, having read 255 during the previous frame. Without it, frame_cnt stays 0 throughout.
